// File: rtl/mem_dp_resp.sv
// Dual-port data-memory responder for the memory-access stage.
// Two independent ports read and write a shared word array with one cycle of
// read latency. A clear engine zeroes the array after reset or on request,
// and ow_ready stays low until that sweep has finished.

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module mem_dp_resp #(
    parameter int P_DEPTH_LOG2 = 12
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_clr,
    input  logic [`SIZE_ADDR-1:0] iw_mem_addr  [0:1],
    input  logic                  iw_mem_we    [0:1],
    input  logic [`SIZE_DATA-1:0] iw_mem_wdata [0:1],
    output logic [`SIZE_DATA-1:0] ow_mem_rdata [0:1],
    output logic                  ow_ready,
    output logic                  ow_conflict
);

    // Port protocol: there is no valid/ready handshake on the ports. In S_RUN
    // every cycle is an accepted access on both ports (a read always, a write
    // when iw_mem_we is high); in S_CLEAR port accesses are ignored. ow_ready
    // tells the requester which of the two applies.

    localparam int DEPTH = 1 << P_DEPTH_LOG2;
    localparam int DW    = `SIZE_DATA;

    localparam logic S_CLEAR = 1'b0;
    localparam logic S_RUN   = 1'b1;

    localparam logic [P_DEPTH_LOG2-1:0] CNT_LAST = '1;

    // FSM state; kept as a plain named signal so checkers can bind to it.
    logic                    state;
    logic [P_DEPTH_LOG2-1:0] cnt;

    logic [DW-1:0]           mem [0:DEPTH-1];

    logic [P_DEPTH_LOG2-1:0] idx0;
    logic [P_DEPTH_LOG2-1:0] idx1;
    logic                    wr0;
    logic                    wr1;
    logic                    same_idx;
    logic [DW-1:0]           rd_val0;
    logic [DW-1:0]           rd_val1;

    // Upper address bits alias away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{iw_mem_addr[0][`SIZE_ADDR-1:P_DEPTH_LOG2],
                              iw_mem_addr[1][`SIZE_ADDR-1:P_DEPTH_LOG2]};

    assign idx0     = iw_mem_addr[0][P_DEPTH_LOG2-1:0];
    assign idx1     = iw_mem_addr[1][P_DEPTH_LOG2-1:0];
    // Port writes only count while the array is in service.
    assign wr0      = (state == S_RUN) && iw_mem_we[0];
    assign wr1      = (state == S_RUN) && iw_mem_we[1];
    assign same_idx = (idx0 == idx1);

    assign ow_ready = (state == S_RUN);

    // Write-first read data: port 0 write beats port 1 write beats stored word.
    always_comb begin
        rd_val0 = mem[idx0];
        if (wr1 && same_idx) rd_val0 = iw_mem_wdata[1];
        if (wr0)             rd_val0 = iw_mem_wdata[0];

        rd_val1 = mem[idx1];
        if (wr1)             rd_val1 = iw_mem_wdata[1];
        if (wr0 && same_idx) rd_val1 = iw_mem_wdata[0];
    end

    // Clear sequencing: sweep cnt across the array, then serve ports until a clear request.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (iw_clr) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (iw_clr) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Array update: clear engine owns the array in S_CLEAR; port 0 is applied last so it wins.
    always_ff @(posedge iw_clk) begin
        if (state == S_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr1) mem[idx1] <= iw_mem_wdata[1];
            if (wr0) mem[idx0] <= iw_mem_wdata[0];
        end
    end

    // Registered outputs: read data and the same-index double-write pulse.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ow_mem_rdata[0] <= '0;
            ow_mem_rdata[1] <= '0;
            ow_conflict     <= 1'b0;
        end else if (state == S_RUN) begin
            ow_mem_rdata[0] <= rd_val0;
            ow_mem_rdata[1] <= rd_val1;
            ow_conflict     <= wr0 && wr1 && same_idx;
        end else begin
            ow_mem_rdata[0] <= '0;
            ow_mem_rdata[1] <= '0;
            ow_conflict     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_dp_resp.sv
// Testbench for mem_dp_resp with a 16-word array.
// A behavioural model predicts outputs every cycle; directed checks pin
// reset timing, write-first reads, conflicts, aliasing, clear and reset.

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_mem_dp_resp;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = `SIZE_ADDR;
    localparam int DW    = `SIZE_DATA;
    localparam int EW    = 2 * DW + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [AW-1:0] addr  [0:1];
    logic          we    [0:1];
    logic [DW-1:0] wdata [0:1];
    logic [DW-1:0] rdata [0:1];
    logic          ready;
    logic          conflict;

    int checks = 0;
    int errors = 0;

    // Expected {conflict, ready, rdata1, rdata0} for the cycle after each edge.
    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_dp_resp #(.P_DEPTH_LOG2(DL)) dut (
        .iw_clk       (clk),
        .iw_rst       (rst),
        .iw_clr       (clr),
        .iw_mem_addr  (addr),
        .iw_mem_we    (we),
        .iw_mem_wdata (wdata),
        .ow_mem_rdata (rdata),
        .ow_ready     (ready),
        .ow_conflict  (conflict)
    );

    // ---------------- behavioural model ----------------
    logic [DW-1:0] model_mem [DEPTH];
    int            clear_left;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        clear_left = DEPTH;
    end

    always @(posedge clk or posedge rst) begin : model
        logic [DW-1:0] nxt [DEPTH];
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic          cf;
        int            i0;
        int            i1;
        if (rst) begin
            clear_left = DEPTH;
            exp_q.delete();
            exp_q.push_back({EW{1'b0}});
        end else if (clear_left > 0) begin
            if (clr) begin
                clear_left = DEPTH;
            end else begin
                clear_left = clear_left - 1;
                if (clear_left == 0)
                    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            end
            exp_q.push_back({1'b0, clear_left == 0, {DW{1'b0}}, {DW{1'b0}}});
        end else begin
            i0 = int'(addr[0] % AW'(DEPTH));
            i1 = int'(addr[1] % AW'(DEPTH));
            nxt = model_mem;
            if (we[1]) nxt[i1] = wdata[1];
            if (we[0]) nxt[i0] = wdata[0];
            cf = we[0] && we[1] && (i0 == i1);
            r0 = nxt[i0];
            r1 = nxt[i1];
            model_mem = nxt;
            if (clr) clear_left = DEPTH;
            exp_q.push_back({cf, clear_left == 0, r1, r0});
        end
    end

    // ---------------- per-cycle scoreboard compare ----------------
    always @(negedge clk) begin : compare
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {conflict, ready, rdata[1], rdata[0]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_model t=%0t got conf=%b rdy=%b rd1=%h rd0=%h expected conf=%b rdy=%b rd1=%h rd0=%h",
                         $time, a[EW-1], a[EW-2], a[2*DW-1:DW], a[DW-1:0],
                         e[EW-1], e[EW-2], e[2*DW-1:DW], e[DW-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we0, input int a0, input int d0,
                         input logic we1, input int a1, input int d1);
        we[0]    = we0;
        addr[0]  = AW'(a0);
        wdata[0] = DW'(d0);
        we[1]    = we1;
        addr[1]  = AW'(a1);
        wdata[1] = DW'(d1);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 0, 0);
        clr = 1'b0;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            checkb(name, ready, i == DEPTH);
        end
    endtask

    task automatic expect_all_zero(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, a, 0, 1'b0, DEPTH - 1 - a, 0);
            tick();
            check(name, rdata[0], '0);
            check(name, rdata[1], '0);
        end
    endtask

    task automatic fill_array();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, a, 'h100 + a, 1'b0, 0, 0);
            tick();
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkb("reset_ready", ready, 1'b0);
        check("reset_rdata0", rdata[0], '0);

        // ready rises exactly 16 cycles after release; array reads zero
        wait_ready("ready_after_reset");
        expect_all_zero("init_zero");

        // write then read by the other port
        drive(1'b1, 3, 'h00A5, 1'b0, 0, 0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 3, 0);
        tick();
        check("wr_then_rd_p1", rdata[1], 'h00A5);

        // same-index double write: port 0 wins, one-cycle conflict pulse
        drive(1'b1, 5, 'h0011, 1'b1, 5, 'h0022);
        tick();
        check("dbl_wr_rd0", rdata[0], 'h0011);
        check("dbl_wr_rd1", rdata[1], 'h0011);
        checkb("dbl_wr_conflict", conflict, 1'b1);
        drive(1'b0, 5, 0, 1'b0, 5, 0);
        tick();
        checkb("conflict_drop", conflict, 1'b0);
        check("dbl_wr_held", rdata[0], 'h0011);

        // aliasing of upper address bits
        drive(1'b0, 0, 0, 1'b1, 'h13, 'h0033);
        tick();
        drive(1'b0, 'h03, 0, 1'b0, 0, 0);
        tick();
        check("alias_rd", rdata[0], 'h0033);

        // two writes to different indices both land
        drive(1'b1, 7, 'h77, 1'b1, 8, 'h88);
        tick();
        checkb("diff_idx_noconf", conflict, 1'b0);
        drive(1'b0, 8, 0, 1'b0, 7, 0);
        tick();
        check("diff_idx_p0", rdata[0], 'h88);
        check("diff_idx_p1", rdata[1], 'h77);

        // write-first: port 1 reads the index port 0 writes in the same cycle
        drive(1'b1, 9, 'h99, 1'b0, 9, 0);
        tick();
        check("wr_first_p1", rdata[1], 'h99);

        // full clear by request, write during clear dropped
        fill_array();
        idle();
        drive(1'b0, 4, 0, 1'b0, 4, 0);
        tick();
        check("filled_rd", rdata[0], 'h104);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkb("clr_ready_low", ready, 1'b0);
        drive(1'b1, 2, 'hDEAD, 1'b0, 0, 0);
        tick();
        checkb("clr_ready_low2", ready, 1'b0);
        idle();
        for (int i = 3; i <= DEPTH + 1; i++) begin
            tick();
            checkb("clr_ready", ready, i == DEPTH + 1);
        end
        expect_all_zero("after_clr");

        // clear request during a clear restarts the sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkb("restart_ready_low", ready, 1'b0);
        wait_ready("restart_ready");

        // reset while serving: outputs drop at once
        fill_array();
        drive(1'b1, 6, 'h66, 1'b1, 6, 'h67);
        tick();
        checkb("pre_rst_conflict", conflict, 1'b1);
        check("pre_rst_rd0", rdata[0], 'h66);
        rst = 1'b1;
        #1;
        checkb("rst_run_conflict", conflict, 1'b0);
        check("rst_run_rd0", rdata[0], '0);
        check("rst_run_rd1", rdata[1], '0);
        checkb("rst_run_ready", ready, 1'b0);
        idle();
        tick();
        rst = 1'b0;

        // reset partway through the resulting clear
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checkb("rst_clr_ready", ready, 1'b0);
        check("rst_clr_rd0", rdata[0], '0);
        checkb("rst_clr_conflict", conflict, 1'b0);
        tick();
        rst = 1'b0;
        wait_ready("ready_after_mid_rst");
        expect_all_zero("after_mid_rst");

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dp_resp.md
Name: mem_dp_resp

Overview:
Dual-port data-memory responder: the memory side of the stage-4 memory-access interface. It accepts per-port write enable, write data and address, and returns per-port read data one cycle later. On reset, or on request, a built-in clear engine zeroes the whole array, and the block reports ready only when clearing is complete. It sits outside the pipeline and connects to the mo stage through the two-entry port arrays selected by the stage's mp bit.

Parameters:
P_DEPTH_LOG2, 12, log2 of the number of words. The array holds 2**P_DEPTH_LOG2 words of `SIZE_DATA bits.

Ports:
iw_clk  in  1  clock; all state updates on the rising edge
iw_rst  in  1  reset; asynchronous, active-high
iw_clr  in  1  pulse that requests a full clear of the array
iw_mem_addr[0:1]  in  `SIZE_ADDR each  word address per port; only the low P_DEPTH_LOG2 bits are used
iw_mem_we[0:1]  in  1 each  write enable per port
iw_mem_wdata[0:1]  in  `SIZE_DATA each  write data per port
ow_mem_rdata[0:1]  out  `SIZE_DATA each  registered read data per port
ow_ready  out  1  high when the array is usable, low while clearing
ow_conflict  out  1  one-cycle pulse on a same-address double write

Behaviour:
- Reset values: ow_mem_rdata[0]=0, ow_mem_rdata[1]=0, ow_ready=0, ow_conflict=0. After reset the state is S_CLEAR and the clear counter is 0.
- Reset is asynchronous. Asserting it mid-operation aborts any access in flight and any clear in progress. Array contents are not reset directly; they become all-zero once the clear engine finishes.
- FSM states: S_CLEAR and S_RUN.
- S_CLEAR:
  - Each cycle writes 0 to array[cnt], then cnt = cnt + 1.
  - When cnt = 2**P_DEPTH_LOG2 - 1 is written, the next state is S_RUN.
  - ow_ready rises in the first S_RUN cycle, so ow_ready is 1 exactly 2**P_DEPTH_LOG2 cycles after reset release.
  - iw_clr asserted in S_CLEAR restarts cnt at 0.
  - Port writes are dropped and ow_mem_rdata is driven 0.
- S_RUN:
  - iw_clr asserted means the next state is S_CLEAR with cnt=0 and ow_ready=0 on the next edge.
  - Port accesses issued in that same cycle still complete normally.
- Addressing: index = iw_mem_addr[p][P_DEPTH_LOG2-1:0]. Upper address bits are ignored, so addresses alias modulo the depth.
- Writes: when iw_mem_we[p]=1, array[index_p] <= iw_mem_wdata[p] at the edge.
- Reads: every cycle, whether or not a write is enabled, ow_mem_rdata[p] <= the data at index_p. Latency is 1 cycle and there is no stall.
- Read-during-write is write-first:
  - If any port writes index X in cycle N, a read of X by either port in cycle N returns the winning write data in cycle N+1.
- Double write to the same index in the same cycle:
  - Port 0 wins; port 1's data is discarded.
  - ow_conflict=1 for exactly the next cycle, otherwise 0.
  - Both ports' read data for that index return port 0's data.
- Two writes to different indices in the same cycle both complete.
- Clear-engine writes never raise ow_conflict.

Test Plan:
- Bench uses P_DEPTH_LOG2=4. Release reset at cycle 0 -> ow_ready=0 for cycles 0..15 and ow_ready=1 at cycle 16; reads of addresses 0..15 return 0.
- Port 0 writes 0x00A5 to address 3 in cycle N; port 1 reads address 3 in cycle N+1 -> ow_mem_rdata[1]=0x00A5 in cycle N+2.
- Cycle N: port 0 writes 0x0011 to address 5 and port 1 writes 0x0022 to address 5, both ports reading address 5 -> in cycle N+1 both rdata=0x0011 and ow_conflict=1; in cycle N+2 ow_conflict=0 and address 5 still holds 0x0011.
- Port 1 writes 0x0033 to address 0x13 -> a port 0 read of address 0x03 returns 0x0033 (aliasing).
- After filling the array with non-zero data, pulse iw_clr -> ow_ready=0 on the next edge and stays 0 for 16 cycles; a port write during the clear is dropped; all reads return 0 afterwards.
- Assert iw_rst for 1 cycle partway through a clear -> all outputs are 0 immediately; ow_ready returns exactly 16 cycles after release; array reads as all 0.
